// File: rtl/ddr5_sched_pkg.sv
// Shared types and address-field layout for the DDR5 request path.
// Widths here are the default build; modules derive offsets from their own parameters.
package ddr5_sched_pkg;

  localparam int BYTE_W   = 2;
  localparam int COL_LO_W = 4;
  localparam int COL_HI_W = 6;
  localparam int COL_W    = COL_LO_W + COL_HI_W;

  localparam int DEF_ROW_W = 16;
  localparam int DEF_BG_W  = 3;
  localparam int DEF_BA_W  = 2;
  localparam int DEF_CH_W  = 1;

  typedef enum logic [1:0] {
    OP_D_READ  = 2'd0,
    OP_WRITE   = 2'd1,
    OP_I_READ  = 2'd2,
    OP_ILLEGAL = 2'd3
  } op_e;

  // Field offsets, LSB first: byte_sel, col_low, ch, bg, bank, col_high, row.
  localparam int OFF_COL_LO = BYTE_W;
  localparam int OFF_CH     = OFF_COL_LO + COL_LO_W;

  function automatic int off_bg(input int ch_w);
    return OFF_CH + ch_w;
  endfunction

  function automatic int off_ba(input int ch_w, input int bg_w);
    return off_bg(ch_w) + bg_w;
  endfunction

  function automatic int off_col_hi(input int ch_w, input int bg_w, input int ba_w);
    return off_ba(ch_w, bg_w) + ba_w;
  endfunction

  function automatic int off_row(input int ch_w, input int bg_w, input int ba_w);
    return off_col_hi(ch_w, bg_w, ba_w) + COL_HI_W;
  endfunction

  typedef struct packed {
    logic [DEF_ROW_W-1:0] row;
    logic [COL_W-1:0]     col;
    logic [DEF_BA_W-1:0]  bank;
    logic [DEF_BG_W-1:0]  bg;
    logic [DEF_CH_W-1:0]  ch;
  } dec_addr_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] cycle;
    logic [3:0]  core;
    op_e         op;
    dec_addr_t   addr;
  } queue_entry_t;

endpackage

// File: rtl/ddr5_addr_decode.sv
// Combinational split of a byte address into row, column, bank, bank group and channel.
module ddr5_addr_decode
  import ddr5_sched_pkg::*;
#(
  parameter int ROW_W  = 16,
  parameter int BG_W   = 3,
  parameter int BA_W   = 2,
  parameter int CH_W   = 1,
  parameter int ADDR_W = ROW_W + BA_W + BG_W + CH_W + 12
) (
  input  logic [ADDR_W-1:0] addr_i,
  output logic [ROW_W-1:0]  row_o,
  output logic [COL_W-1:0]  col_o,
  output logic [BA_W-1:0]   bank_o,
  output logic [BG_W-1:0]   bg_o,
  output logic [CH_W-1:0]   ch_o
);

  localparam int BG_LSB     = off_bg(CH_W);
  localparam int BA_LSB     = off_ba(CH_W, BG_W);
  localparam int COL_HI_LSB = off_col_hi(CH_W, BG_W, BA_W);
  localparam int ROW_LSB    = off_row(CH_W, BG_W, BA_W);

  assign row_o  = addr_i[ROW_LSB +: ROW_W];
  assign col_o  = {addr_i[COL_HI_LSB +: COL_HI_W], addr_i[OFF_COL_LO +: COL_LO_W]};
  assign bank_o = addr_i[BA_LSB +: BA_W];
  assign bg_o   = addr_i[BG_LSB +: BG_W];
  assign ch_o   = addr_i[OFF_CH +: CH_W];

  logic unused_byte_sel;
  assign unused_byte_sel = ^addr_i[BYTE_W-1:0];

endmodule

// File: rtl/ddr5_request_queue.sv
// Age-ordered request queue feeding the DDR5 scheduler; entries release once their CPU cycle arrives.
// Define DDR5_REQ_QUEUE_FRFCFS_EN for row-hit-first release with a starvation cap.
module ddr5_request_queue
  import ddr5_sched_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int ROW_W   = 16,
  parameter int BG_W    = 3,
  parameter int BA_W    = 2,
  parameter int CH_W    = 1,
  parameter int AGE_MAX = 4,
  parameter int ADDR_W  = ROW_W + BA_W + BG_W + CH_W + 12
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [63:0]            now_cycle,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [63:0]            in_cycle,
  input  logic [3:0]             in_core,
  input  logic [1:0]             in_op,
  input  logic [ADDR_W-1:0]      in_addr,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ROW_W-1:0]       out_row,
  output logic [COL_W-1:0]       out_col,
  output logic [BA_W-1:0]        out_bank,
  output logic [BG_W-1:0]        out_bg,
  output logic [CH_W-1:0]        out_ch,
  output logic [1:0]             out_op,
  output logic [3:0]             out_core,
  output logic [63:0]            out_cycle,
  output logic [$clog2(DEPTH):0] count,
  output logic                   err_op
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;

  typedef struct packed {
    logic             valid;
    logic [63:0]      cycle;
    logic [3:0]       core;
    op_e              op;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
    logic [BA_W-1:0]  bank;
    logic [BG_W-1:0]  bg;
    logic [CH_W-1:0]  ch;
  } entry_t;

  entry_t           q_q [DEPTH];
  entry_t           q_d [DEPTH];
  entry_t           new_entry, out_ent_q, out_ent_d;
  logic [CNT_W-1:0] count_q, count_d, tail;
  logic [IDX_W-1:0] out_sel_q, out_sel_d, sel_idx;
  logic             ready_q, out_valid_q, out_valid_d, err_op_q, err_op_d;
  logic             sel_found, push, push_store, pop;

  logic [ROW_W-1:0] dec_row;
  logic [COL_W-1:0] dec_col;
  logic [BA_W-1:0]  dec_bank;
  logic [BG_W-1:0]  dec_bg;
  logic [CH_W-1:0]  dec_ch;

  ddr5_addr_decode #(
    .ROW_W(ROW_W), .BG_W(BG_W), .BA_W(BA_W), .CH_W(CH_W), .ADDR_W(ADDR_W)
  ) u_decode (
    .addr_i(in_addr), .row_o(dec_row), .col_o(dec_col),
    .bank_o(dec_bank), .bg_o(dec_bg), .ch_o(dec_ch)
  );

  assign in_ready   = ready_q && (count_q < CNT_W'(DEPTH)) && !flush;
  assign push       = in_valid && in_ready;
  assign push_store = push && (in_op != OP_ILLEGAL);
  assign pop        = out_valid_q && out_ready && !flush;

  always_comb begin
    new_entry = '{valid: 1'b1, cycle: in_cycle, core: in_core, op: op_e'(in_op),
                  row: dec_row, col: dec_col, bank: dec_bank, bg: dec_bg, ch: dec_ch};
  end

`ifdef DDR5_REQ_QUEUE_FRFCFS_EN
  localparam int KEY_W = BG_W + BA_W;
  localparam int NB    = 1 << KEY_W;
  localparam int BYP_W = $clog2(AGE_MAX + 1);

  logic [NB-1:0]    open_valid_q, open_valid_d;
  logic [ROW_W-1:0] open_row_q [NB];
  logic [ROW_W-1:0] open_row_d [NB];
  logic [BYP_W-1:0] bypass_q, bypass_d;
  logic             oldest_found, hit_found, cur_hit, forced, upgrade;
  logic [IDX_W-1:0] oldest_idx, hit_idx;

  function automatic logic [KEY_W-1:0] key_of(input entry_t e);
    return {e.bg, e.bank};
  endfunction

  // Scanning from the tail down leaves the lowest (oldest) matching index.
  always_comb begin
    oldest_found = 1'b0;
    hit_found    = 1'b0;
    oldest_idx   = '0;
    hit_idx      = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (q_q[i].valid && (q_q[i].cycle <= now_cycle)) begin
        oldest_found = 1'b1;
        oldest_idx   = IDX_W'(i);
        if (open_valid_q[key_of(q_q[i])] && (open_row_q[key_of(q_q[i])] == q_q[i].row)) begin
          hit_found = 1'b1;
          hit_idx   = IDX_W'(i);
        end
      end
    end
    cur_hit   = open_valid_q[key_of(q_q[out_sel_q])] &&
                (open_row_q[key_of(q_q[out_sel_q])] == q_q[out_sel_q].row);
    forced    = (bypass_q == BYP_W'(AGE_MAX));
    upgrade   = hit_found && !cur_hit && !forced;
    sel_found = oldest_found;
    sel_idx   = (hit_found && !forced) ? hit_idx : oldest_idx;
  end

  always_comb begin
    open_valid_d = open_valid_q;
    open_row_d   = open_row_q;
    bypass_d     = bypass_q;
    if (flush) begin
      open_valid_d = '0;
      bypass_d     = '0;
    end else if (pop) begin
      open_valid_d[key_of(q_q[out_sel_q])] = 1'b1;
      open_row_d[key_of(q_q[out_sel_q])]   = q_q[out_sel_q].row;
      if (oldest_found && (out_sel_q == oldest_idx)) bypass_d = '0;
      else if (!forced)                                bypass_d = bypass_q + BYP_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      open_valid_q <= '0;
      bypass_q     <= '0;
      for (int i = 0; i < NB; i++) open_row_q[i] <= '0;
    end else begin
      open_valid_q <= open_valid_d;
      open_row_q   <= open_row_d;
      bypass_q     <= bypass_d;
    end
  end
`else
  // An ineligible head blocks everything behind it.
  always_comb begin
    sel_found = q_q[0].valid && (q_q[0].cycle <= now_cycle);
    sel_idx   = '0;
  end

  logic [31:0] unused_age_max;
  assign unused_age_max = 32'(AGE_MAX);
`endif

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    q_d      = q_q;
    tail     = count_q;
    if (pop) begin
      for (int i = 0; i < DEPTH - 1; i++)
        if (IDX_W'(i) >= out_sel_q) q_d[i] = q_q[i+1];
      q_d[DEPTH-1] = '0;
      tail         = count_q - CNT_W'(1);
    end
    if (push_store) q_d[tail[IDX_W-1:0]] = new_entry;
    if (flush)
      for (int i = 0; i < DEPTH; i++) q_d[i] = '0;
    count_d  = flush ? '0 : count_q + CNT_W'(push_store) - CNT_W'(pop);
    err_op_d = push && (in_op == OP_ILLEGAL);
  end

  // A pop always leaves one idle cycle so the next choice sees the shifted queue.
  always_comb begin
    out_valid_d = out_valid_q;
    out_sel_d   = out_sel_q;
    out_ent_d   = out_ent_q;
    if (flush || pop) begin
      out_valid_d = 1'b0;
    end else if (!out_valid_q) begin
      out_valid_d = sel_found;
      out_sel_d   = sel_idx;
      out_ent_d   = q_q[sel_idx];
    end
`ifdef DDR5_REQ_QUEUE_FRFCFS_EN
    else if (upgrade) begin
      out_sel_d = hit_idx;
      out_ent_d = q_q[hit_idx];
    end
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the entry storage is reset too, so no X can reach the payload outputs.
      for (int i = 0; i < DEPTH; i++) q_q[i] <= '0;
      count_q     <= '0;
      ready_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_sel_q   <= '0;
      out_ent_q   <= '0;
      err_op_q    <= 1'b0;
    end else begin
      q_q         <= q_d;
      count_q     <= count_d;
      ready_q     <= 1'b1;
      out_valid_q <= out_valid_d;
      out_sel_q   <= out_sel_d;
      out_ent_q   <= out_ent_d;
      err_op_q    <= err_op_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_row   = out_ent_q.row;
  assign out_col   = out_ent_q.col;
  assign out_bank  = out_ent_q.bank;
  assign out_bg    = out_ent_q.bg;
  assign out_ch    = out_ent_q.ch;
  assign out_op    = out_ent_q.op;
  assign out_core  = out_ent_q.core;
  assign out_cycle = out_ent_q.cycle;
  assign count     = count_q;
  assign err_op    = err_op_q;

  logic unused_out_valid_bit;
  assign unused_out_valid_bit = out_ent_q.valid;

endmodule
